// File: rtl/aes_data_in_stage_pkg.sv
// aes_data_in_stage_pkg: shared AES state sizing and word-index type
package aes_data_in_stage_pkg;
  localparam int NUM_STATE_WORDS = 4;
  localparam int STATE_W = 128;
  typedef logic [1:0] word_idx_t;
endpackage

// File: rtl/aes_data_in_stage.sv
// aes_data_in_stage: stages four 32-bit words and hands a 128-bit block to the AES core
// Ports: clk_i/rst_ni clock and sync active-low reset; wr_en_i/wr_data_i per-word staging writes;
//   manual_op_i/start_i transfer mode and trigger; clear_i sync clear; out_valid_o/out_ready_i
//   core handshake; state_init_o held block; stage_full_o/start_pend_o/stall_o status.
module aes_data_in_stage
  import aes_data_in_stage_pkg::*;
#(
  parameter int NumWords = NUM_STATE_WORDS,
  parameter logic [STATE_W-1:0] ResetVal = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumWords-1:0] wr_en_i,
  input  logic [31:0]         wr_data_i,
  input  logic                manual_op_i,
  input  logic                start_i,
  input  logic                clear_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [STATE_W-1:0]  state_init_o,
  output logic                stage_full_o,
  output logic                start_pend_o,
  output logic                stall_o
);
  logic [STATE_W-1:0]  r_stage, r_hold;
  logic [NumWords-1:0] r_written;
  logic                r_valid, r_pend;
  logic                w_hold_free, w_full, w_go;
  assign w_hold_free  = !r_valid || out_ready_i;
  assign w_full       = &r_written;
  assign w_go         = w_full && (!manual_op_i || r_pend || start_i) && w_hold_free;
  assign out_valid_o  = r_valid;
  assign state_init_o = r_hold;
  assign stage_full_o = w_full;
  assign start_pend_o = r_pend;
  assign stall_o      = w_full && (!manual_op_i || r_pend) && !w_hold_free;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_stage   <= ResetVal;
      r_hold    <= ResetVal;
      r_written <= '0;
      r_valid   <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      for (int i = 0; i < NumWords; i++)
        if (wr_en_i[i]) r_stage[32*i +: 32] <= wr_data_i;
      // a write in the transfer cycle counts toward the next block
      r_written <= (w_go ? '0 : r_written) | wr_en_i;
      r_pend    <= w_go ? 1'b0 : (r_pend || (manual_op_i && start_i));
      if (w_go) r_hold <= r_stage;
      r_valid   <= w_go || (r_valid && !out_ready_i);
    end
  end
endmodule
